// File: rtl/rom_pkg.sv
// Shared constants and the fixed content table for the 16 x 16 lookup ROM.
package rom_pkg;

   localparam int ROM_DATA_W = 16;
   localparam int ROM_ADDR_W = 4;
   localparam int ROM_DEPTH  = 16;

   localparam logic [ROM_DATA_W-1:0] ROM_INIT [0:ROM_DEPTH-1] = '{
      16'h5601, 16'h3401, 16'h7802, 16'h2303,
      16'h1A04, 16'h0B05, 16'h4C06, 16'h6D07,
      16'h9E08, 16'hAF09, 16'hB00A, 16'hC10B,
      16'hD20C, 16'hE30D, 16'hF40E, 16'h5401
   };

endpackage

// File: rtl/rom_lut.sv
// Combinational address-to-word decode of the fixed ROM contents.
module rom_lut
   import rom_pkg::*;
(
   input  logic [ROM_ADDR_W-1:0] addr,
   output logic [ROM_DATA_W-1:0] data
);

   // Full decode of the 16 constant words
   always_comb begin
      data = 16'h0000;
      case (addr)
         4'h0:    data = 16'h5601;
         4'h1:    data = 16'h3401;
         4'h2:    data = 16'h7802;
         4'h3:    data = 16'h2303;
         4'h4:    data = 16'h1A04;
         4'h5:    data = 16'h0B05;
         4'h6:    data = 16'h4C06;
         4'h7:    data = 16'h6D07;
         4'h8:    data = 16'h9E08;
         4'h9:    data = 16'hAF09;
         4'hA:    data = 16'hB00A;
         4'hB:    data = 16'hC10B;
         4'hC:    data = 16'hD20C;
         4'hD:    data = 16'hE30D;
         4'hE:    data = 16'hF40E;
         4'hF:    data = 16'h5401;
         default: data = 16'h0000;
      endcase
   end

endmodule

// File: rtl/rom.sv
// 16-word ROM with a registered one-cycle read port and a valid flag.
module rom
   import rom_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] out,
   output logic              out_valid
);

   logic [ROM_DATA_W-1:0] lut_data;
   logic [DATA_W-1:0]     out_d;
   logic [DATA_W-1:0]     out_q;
   logic                  out_valid_d;
   logic                  out_valid_q;

   rom_lut u_lut (
      .addr (addr),
      .data (lut_data)
   );

   // Next-state: every edge out of reset captures the looked-up word
   always_comb begin
      out_d       = lut_data;
      out_valid_d = 1'b1;
   end

   // Output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rom.sv
// Self-checking bench for rom: directed scenarios plus randomized reads against a table model.
module tb_rom;

   logic        clk;
   logic        rst_n;
   logic [3:0]  addr;
   logic [15:0] out;
   logic        out_valid;

   int tests_run;
   int tests_failed;

   logic [15:0] tbl [0:15] = '{
      16'h5601, 16'h3401, 16'h7802, 16'h2303,
      16'h1A04, 16'h0B05, 16'h4C06, 16'h6D07,
      16'h9E08, 16'hAF09, 16'hB00A, 16'hC10B,
      16'hD20C, 16'hE30D, 16'hF40E, 16'h5401
   };

   rom dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs away from the edge, then settle just after the next rising edge
   task automatic drive(input logic [3:0] a, input logic r);
      @(negedge clk);
      addr  = a;
      rst_n = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(4'h3, 1'b0);
         tests_run++;
         if (out !== 16'h0000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: out=%h valid=%b, want 0000/0", out, out_valid);
         end
      end
      drive(4'h3, 1'b1);
      tests_run++;
      if (out !== 16'h2303 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: out=%h valid=%b, want 2303/1", out, out_valid);
      end
   endtask

   task automatic test_directed();
      logic [3:0]  a [0:2] = '{4'h0, 4'h1, 4'hF};
      logic [15:0] e [0:2] = '{16'h5601, 16'h3401, 16'h5401};
      for (int i = 0; i < 3; i++) begin
         drive(a[i], 1'b1);
         tests_run++;
         if (out !== e[i] || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL directed addr=%0d: out=%h valid=%b, want %h/1", a[i], out, out_valid, e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int good;
      good = 0;
      for (int i = 0; i < 16; i++) begin
         drive(4'(i), 1'b1);
         tests_run++;
         if (out !== tbl[i] || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep addr=%0d: out=%h valid=%b, want %h/1", i, out, out_valid, tbl[i]);
         end else begin
            good++;
         end
      end
      tests_run++;
      if (good != 16) begin
         tests_failed++;
         $display("FAIL sweep_streak: got %0d consecutive good words, want 16", good);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         drive(4'hA, 1'b1);
         tests_run++;
         if (out !== 16'hB00A) begin
            tests_failed++;
            $display("FAIL hold cycle=%0d: out=%h, want b00a", i, out);
         end
      end
      // Address wiggles between edges must not reach the output
      addr = 4'h5;
      #2;
      addr = 4'hE;
      #1;
      tests_run++;
      if (out !== 16'hB00A || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_toggle: out=%h valid=%b, want b00a/1", out, out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 8; i++) begin
         logic r;
         logic [15:0] e;
         r = (i != 4);
         drive(4'(i), r);
         e = r ? tbl[i] : 16'h0000;
         tests_run++;
         if (out !== e || out_valid !== r) begin
            tests_failed++;
            $display("FAIL midreset step=%0d: out=%h valid=%b, want %h/%b", i, out, out_valid, e, r);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0]  a [0:2] = '{4'hE, 4'hF, 4'h0};
      logic [15:0] e [0:2] = '{16'hF40E, 16'h5401, 16'h5601};
      for (int i = 0; i < 3; i++) begin
         drive(a[i], 1'b1);
         tests_run++;
         if (out !== e[i]) begin
            tests_failed++;
            $display("FAIL wrap step=%0d: out=%h, want %h", i, out, e[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         logic [3:0]  a;
         logic        r;
         logic [15:0] e;
         a = 4'($urandom_range(15, 0));
         r = ($urandom_range(9, 0) != 0);
         drive(a, r);
         e = r ? tbl[a] : 16'h0000;
         tests_run++;
         if (out !== e || out_valid !== r) begin
            tests_failed++;
            $display("FAIL random i=%0d addr=%0d rst_n=%b: out=%h valid=%b, want %h/%b",
                     i, a, r, out, out_valid, e, r);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      addr         = 4'h0;
      rst_n        = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold();
      test_reset_midstream();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
